chunked_serial_adder: RTL

//   Multi-cycle WIDTH-bit adder that processes CHUNK bits per clock.
//   A registered carry links the slices, so area is one CHUNK-bit ripple slice

---
 rtl/chunked_serial_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chunked_serial_adder                                         |
// | Description : WIDTH-bit adder evaluated CHUNK bits per clock through a     |
// |               registered carry; start/busy/done handshake.                 |
// |               Optional subtract mode when ADDSUB_EN is defined.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int C_NCHUNK = WIDTH / CHUNK;
    localparam int C_IDX_W  = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_NCHUNK - 1);

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_RUN  = 2'd1;
    localparam logic [1:0] C_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_accept;
    logic               w_last;
    logic               w_sub;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [C_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_acc_next;
    logic [CHUNK:0]     w_slice;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

`ifdef ADDSUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so the operand is inverted once at capture.
    assign w_b_in   = w_sub ? ~b : b;
    assign w_c_in   = w_sub ? 1'b1 : cin;
    assign w_accept = start && (r_state != C_S_RUN);
    assign w_last   = (r_idx == C_LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_S_IDLE: if (start) w_next_state = C_S_RUN;
            C_S_RUN:  if (w_last) w_next_state = C_S_DONE;
            C_S_DONE: w_next_state = start ? C_S_RUN : C_S_IDLE;
            default:  w_next_state = C_S_IDLE;
        endcase
    end

    always_comb begin
        w_slice = {1'b0, r_a[r_idx*CHUNK +: CHUNK]}
                + {1'b0, r_b[r_idx*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, r_carry};
        w_acc_next = r_acc;
        w_acc_next[r_idx*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
    end

    // Accumulation stays private; the visible result only moves on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (r_state == C_S_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_slice[CHUNK];
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_slice[CHUNK];
            end
        end
    end

    assign busy = (r_state == C_S_RUN);
    assign done = (r_state == C_S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
